// File: rtl/exec_alu_unit.sv
// Execute-stage ALU: aluOp/funct decode, 32-bit ALU with zero flag, branch-target adder, registered outputs.
// Optional signed-overflow output enabled by defining ALU_OVERFLOW_EN.
module exec_alu_unit #(
    parameter int WIDTH    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [3:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] branch_imm,
    input  logic             branch,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] branch_target,
    output logic             branch_taken,
    output logic [3:0]       alu_ctrl_q,
    output logic             illegal,
`ifdef ALU_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             out_valid
);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SRA  = 4'b1000;
    localparam logic [3:0] C_LUI  = 4'b1001;
    localparam logic [3:0] C_SLTU = 4'b1010;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_INV  = 4'b1111;

    function automatic logic [3:0] decode_funct(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001: decode_funct = C_ADD;
            6'b100010, 6'b100011: decode_funct = C_SUB;
            6'b100100:            decode_funct = C_AND;
            6'b100101:            decode_funct = C_OR;
            6'b100110:            decode_funct = C_XOR;
            6'b100111:            decode_funct = C_NOR;
            6'b101010:            decode_funct = C_SLT;
            6'b101011:            decode_funct = C_SLTU;
            6'b000000:            decode_funct = C_SLL;
            6'b000010:            decode_funct = C_SRL;
            6'b000011:            decode_funct = C_SRA;
            default:              decode_funct = C_INV;
        endcase
    endfunction

    function automatic logic [3:0] decode_op(input logic [3:0] op, input logic [5:0] f);
        case (op)
            4'b0000: decode_op = C_ADD;
            4'b0001: decode_op = C_SUB;
            4'b0010: decode_op = decode_funct(f);
            4'b0011: decode_op = C_AND;
            4'b0100: decode_op = C_OR;
            4'b0101: decode_op = C_SLT;
            4'b0110: decode_op = C_XOR;
            4'b0111: decode_op = C_LUI;
            default: decode_op = C_INV;
        endcase
    endfunction

    logic [3:0]       w_ctrl;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_target;
    logic             w_illegal;
    logic             w_zero;
    logic             w_ovf;

    assign w_ctrl    = decode_op(alu_op, funct);
    assign w_illegal = (w_ctrl == C_INV);
    assign w_sum     = src_a + src_b;
    assign w_diff    = src_a - src_b;
    assign w_zero    = (w_result == {WIDTH{1'b0}});
    assign w_target  = pc_plus4 + (branch_imm << BR_SHIFT);

    // ALU result mux; INVALID yields zero so the zero flag reads 1
    always_comb begin
        w_result = {WIDTH{1'b0}};
        case (w_ctrl)
            C_AND:   w_result = src_a & src_b;
            C_OR:    w_result = src_a | src_b;
            C_ADD:   w_result = w_sum;
            C_XOR:   w_result = src_a ^ src_b;
            C_SLL:   w_result = src_b << shamt;
            C_SRL:   w_result = src_b >> shamt;
            C_SUB:   w_result = w_diff;
            C_SLT:   w_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            C_SRA:   w_result = $signed(src_b) >>> shamt;
            C_LUI:   w_result = {src_b[15:0], {(WIDTH-16){1'b0}}};
            C_SLTU:  w_result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            C_NOR:   w_result = ~(src_a | src_b);
            default: w_result = {WIDTH{1'b0}};
        endcase
    end

    // Signed overflow only for the trapping forms: add/sub funct and the addi/beq aluOps
    always_comb begin
        w_ovf = 1'b0;
        if ((alu_op == 4'b0000) || ((alu_op == 4'b0010) && (funct == 6'b100000))) begin
            w_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
        end else if ((alu_op == 4'b0001) || ((alu_op == 4'b0010) && (funct == 6'b100010))) begin
            w_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
        end else begin
            w_ovf = 1'b0;
        end
    end

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_target;
    logic             r_taken;
    logic [3:0]       r_ctrl;
    logic             r_illegal;
    logic             r_ovf;
    logic             r_valid;

    // EX/MEM output stage; reset dominates stall, bubbles never flag illegal or taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result  <= {WIDTH{1'b0}};
            r_zero    <= 1'b0;
            r_target  <= {WIDTH{1'b0}};
            r_taken   <= 1'b0;
            r_ctrl    <= 4'b0000;
            r_illegal <= 1'b0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
        end else if (!stall) begin
            r_result  <= w_result;
            r_zero    <= w_zero;
            r_target  <= w_target;
            r_taken   <= in_valid & branch & w_zero;
            r_ctrl    <= w_ctrl;
            r_illegal <= in_valid & w_illegal;
            r_ovf     <= w_ovf;
            r_valid   <= in_valid;
        end
    end

    assign alu_result    = r_result;
    assign zero          = r_zero;
    assign branch_target = r_target;
    assign branch_taken  = r_taken;
    assign alu_ctrl_q    = r_ctrl;
    assign illegal       = r_illegal;
    assign out_valid     = r_valid;
`ifdef ALU_OVERFLOW_EN
    assign overflow      = r_ovf;
`else
    logic w_ovf_unused;
    assign w_ovf_unused  = r_ovf;
`endif

endmodule

// File: tb/tb_exec_alu_unit.sv
// Directed self-checking bench for exec_alu_unit with hand-computed expectations.
module tb_exec_alu_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        stall;
    logic [3:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] pc_plus4;
    logic [31:0] branch_imm;
    logic        branch;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] branch_target;
    logic        branch_taken;
    logic [3:0]  alu_ctrl_q;
    logic        illegal;
    logic        out_valid;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    exec_alu_unit #(.WIDTH(32), .BR_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
        .alu_op(alu_op), .funct(funct), .shamt(shamt),
        .src_a(src_a), .src_b(src_b), .pc_plus4(pc_plus4),
        .branch_imm(branch_imm), .branch(branch),
        .alu_result(alu_result), .zero(zero), .branch_target(branch_target),
        .branch_taken(branch_taken), .alu_ctrl_q(alu_ctrl_q), .illegal(illegal),
`ifdef ALU_OVERFLOW_EN
        .overflow(overflow),
`endif
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic apply(input logic [3:0] op, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        alu_op = op; funct = f; shamt = sh; src_a = a; src_b = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".result"}, alu_result, 32'h0);
        check({tag, ".zero"}, {31'h0, zero}, 32'h0);
        check({tag, ".target"}, branch_target, 32'h0);
        check({tag, ".taken"}, {31'h0, branch_taken}, 32'h0);
        check({tag, ".ctrl"}, {28'h0, alu_ctrl_q}, 32'h0);
        check({tag, ".illegal"}, {31'h0, illegal}, 32'h0);
        check({tag, ".valid"}, {31'h0, out_valid}, 32'h0);
`ifdef ALU_OVERFLOW_EN
        check({tag, ".ovf"}, {31'h0, overflow}, 32'h0);
`endif
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b1; stall = 1'b0; branch = 1'b0;
        pc_plus4 = 32'h0000_0100; branch_imm = 32'h0000_0004;
        apply(4'b0000, 6'b000000, 5'd0, 32'd5, 32'd7);
        #12;
        check_all_zero("reset");

        @(negedge clk); reset = 1'b1;
        step();
        check("add.result", alu_result, 32'd12);
        check("add.zero", {31'h0, zero}, 32'h0);
        check("add.valid", {31'h0, out_valid}, 32'h1);
        check("add.ctrl", {28'h0, alu_ctrl_q}, 32'h2);
        check("add.target", branch_target, 32'h0000_0110);

        apply(4'b0010, 6'b101010, 5'd0, 32'hFFFF_FFFE, 32'h1); step();
        check("slt.result", alu_result, 32'h1);
        check("slt.ctrl", {28'h0, alu_ctrl_q}, 32'h7);
        apply(4'b0010, 6'b101011, 5'd0, 32'hFFFF_FFFE, 32'h1); step();
        check("sltu.result", alu_result, 32'h0);
        check("sltu.ctrl", {28'h0, alu_ctrl_q}, 32'hA);
        apply(4'b0010, 6'b100111, 5'd0, 32'hFFFF_FFFE, 32'h1); step();
        check("nor.result", alu_result, 32'h0);
        check("nor.zero", {31'h0, zero}, 32'h1);
        check("nor.ctrl", {28'h0, alu_ctrl_q}, 32'hC);
        apply(4'b0010, 6'b000011, 5'd4, 32'hFFFF_FFFE, 32'h8000_0000); step();
        check("sra.result", alu_result, 32'hF800_0000);
        check("sra.ctrl", {28'h0, alu_ctrl_q}, 32'h8);
        apply(4'b0010, 6'b000010, 5'd4, 32'h0, 32'h8000_0000); step();
        check("srl.result", alu_result, 32'h0800_0000);
        apply(4'b0010, 6'b000000, 5'd3, 32'h0, 32'h0000_0011); step();
        check("sll.result", alu_result, 32'h0000_0088);
        apply(4'b0010, 6'b100011, 5'd0, 32'd3, 32'd5); step();
        check("subu.result", alu_result, 32'hFFFF_FFFE);
        apply(4'b0011, 6'b111111, 5'd0, 32'h0000_0F0F, 32'h0000_00FF); step();
        check("andi.result", alu_result, 32'h0000_000F);
        apply(4'b0100, 6'b111111, 5'd0, 32'h0000_0F00, 32'h0000_00F0); step();
        check("ori.result", alu_result, 32'h0000_0FF0);
        apply(4'b0110, 6'b000000, 5'd0, 32'hFF00_FF00, 32'h0F0F_0F0F); step();
        check("xori.result", alu_result, 32'hF00F_F00F);
        apply(4'b0101, 6'b000000, 5'd0, 32'h8000_0000, 32'h0000_0001); step();
        check("slti.result", alu_result, 32'h1);

        branch = 1'b1; pc_plus4 = 32'h0000_0100; branch_imm = 32'hFFFF_FFFE;
        apply(4'b0001, 6'b000000, 5'd0, 32'h1234, 32'h1234); step();
        check("beq.zero", {31'h0, zero}, 32'h1);
        check("beq.taken", {31'h0, branch_taken}, 32'h1);
        check("beq.target", branch_target, 32'h0000_00F8);
        apply(4'b0001, 6'b000000, 5'd0, 32'h1234, 32'h1235); step();
        check("bne.taken", {31'h0, branch_taken}, 32'h0);
        check("bne.result", alu_result, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        apply(4'b0001, 6'b000000, 5'd0, 32'h1234, 32'h1234); step();
        check("bubble.taken", {31'h0, branch_taken}, 32'h0);
        check("bubble.valid", {31'h0, out_valid}, 32'h0);
        check("bubble.zero", {31'h0, zero}, 32'h1);
        apply(4'b1000, 6'b000000, 5'd0, 32'h1, 32'h1); step();
        check("bubble.illegal", {31'h0, illegal}, 32'h0);
        check("bubble.ctrl", {28'h0, alu_ctrl_q}, 32'hF);
        in_valid = 1'b1; branch = 1'b0;
        apply(4'b1001, 6'b000000, 5'd0, 32'h1, 32'h1); step();
        check("illop.illegal", {31'h0, illegal}, 32'h1);

        pc_plus4 = 32'h0000_0200; branch_imm = 32'h0000_0001;
        apply(4'b0010, 6'b111111, 5'd0, 32'h55, 32'h66); step();
        check("illf.illegal", {31'h0, illegal}, 32'h1);
        check("illf.ctrl", {28'h0, alu_ctrl_q}, 32'hF);
        check("illf.result", alu_result, 32'h0);
        check("illf.zero", {31'h0, zero}, 32'h1);
        check("illf.target", branch_target, 32'h0000_0204);
        stall = 1'b1; in_valid = 1'b0; pc_plus4 = 32'h0000_1000;
        apply(4'b0000, 6'b000000, 5'd0, 32'h1, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.result", alu_result, 32'h0);
            check("stall.illegal", {31'h0, illegal}, 32'h1);
            check("stall.ctrl", {28'h0, alu_ctrl_q}, 32'hF);
            check("stall.valid", {31'h0, out_valid}, 32'h1);
            check("stall.target", branch_target, 32'h0000_0204);
        end
        #2 reset = 1'b0;
        #1 check_all_zero("rst_stall");
        reset = 1'b1;
        stall = 1'b0; in_valid = 1'b1;
        @(negedge clk);

        apply(4'b0000, 6'b000000, 5'd0, 32'hFFFF_FFFF, 32'h1); step();
        check("wrap.result", alu_result, 32'h0);
        check("wrap.zero", {31'h0, zero}, 32'h1);
`ifdef ALU_OVERFLOW_EN
        check("wrap.ovf", {31'h0, overflow}, 32'h0);
`endif
        apply(4'b0111, 6'b000000, 5'd0, 32'h0, 32'h0000_ABCD); step();
        check("lui.result", alu_result, 32'hABCD_0000);
        check("lui.ctrl", {28'h0, alu_ctrl_q}, 32'h9);
`ifdef ALU_OVERFLOW_EN
        apply(4'b0000, 6'b000000, 5'd0, 32'h7FFF_FFFF, 32'h1); step();
        check("ovf.add", {31'h0, overflow}, 32'h1);
        apply(4'b0010, 6'b100001, 5'd0, 32'h7FFF_FFFF, 32'h1); step();
        check("ovf.addu", {31'h0, overflow}, 32'h0);
        apply(4'b0010, 6'b100010, 5'd0, 32'h8000_0000, 32'h1); step();
        check("ovf.sub", {31'h0, overflow}, 32'h1);
`endif

        apply(4'b0000, 6'b000000, 5'd0, 32'd40, 32'd2); step();
        check("pre_rst.result", alu_result, 32'd42);
        #2 reset = 1'b0;
        #1 check_all_zero("async_rst");
        #1 reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
